// File: rtl/aes_inv_cipher_if.sv
`default_nettype none
// ============================================================================
// Module  : aes_inv_cipher_if
// Brief   : Request/response and external S-box signals of the AES-128
//           inverse cipher, bundled with host (master) and engine (slave) views.
// Revision: 1.0 - initial release
// ============================================================================
interface aes_inv_cipher_if;
  logic         load;
  logic [127:0] key;
  logic [127:0] ciphertext;
  logic [127:0] plaintext;
  logic         done;
  logic         busy;
  logic [31:0]  subword_in;
  logic [31:0]  subword_out;
  logic [127:0] invsub_in;
  logic [127:0] invsub_out;

  modport master (
    output load, key, ciphertext, subword_out, invsub_out,
    input  plaintext, done, busy, subword_in, invsub_in
  );

  modport slave (
    input  load, key, ciphertext, subword_out, invsub_out,
    output plaintext, done, busy, subword_in, invsub_in
  );
endinterface
`default_nettype wire

// File: rtl/aes_inv_cipher.sv
`default_nettype none
// ============================================================================
// Module  : aes_inv_cipher
// Brief   : Iterative AES-128 decryption, one round per clock, with external
//           forward/inverse S-boxes. Optional key cache: AES_INV_KEY_CACHE_EN.
// Revision: 1.0 - initial release
// ============================================================================
module aes_inv_cipher #(
  parameter int NR = 10
) (
  input  logic            clk,
  input  logic            reset,
  aes_inv_cipher_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_KEXP  = 3'd1,
    S_INIT  = 3'd2,
    S_ROUND = 3'd3,
    S_FINAL = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  state_t       r_state;
  state_t       w_next;
  logic [3:0]   r_rc;
  logic [127:0] r_blk;
  logic [127:0] r_pt;
  logic         r_done;
  logic         r_busy;
  logic [127:0] r_rk [0:NR];

  logic         w_accept;
  logic         w_hit;
  logic [3:0]   w_prev_idx;
  logic [127:0] w_rk_prev;
  logic [127:0] w_rk_next;
  logic [31:0]  w_temp;
  logic [31:0]  w_k0, w_k1, w_k2, w_k3;

  function automatic logic [7:0] rcon(input logic [3:0] idx);
    case (idx)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Byte i sits at [127-8i -: 8]; byte index = 4*column + row.
  function automatic logic [127:0] inv_shift_rows(input logic [127:0] x);
    logic [127:0] y;
    y = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        y[127-8*(4*c+r) -: 8] = x[127-8*(4*((c-r+4)%4)+r) -: 8];
      end
    end
    return y;
  endfunction

  function automatic logic [31:0] inv_mix_col(input logic [31:0] col);
    logic [7:0] a [4];
    logic [7:0] m9 [4];
    logic [7:0] mb [4];
    logic [7:0] md [4];
    logic [7:0] me [4];
    logic [7:0] x2, x4, x8;
    for (int i = 0; i < 4; i++) begin
      a[i]  = col[31-8*i -: 8];
      x2    = xt(a[i]);
      x4    = xt(x2);
      x8    = xt(x4);
      m9[i] = x8 ^ a[i];
      mb[i] = x8 ^ x2 ^ a[i];
      md[i] = x8 ^ x4 ^ a[i];
      me[i] = x8 ^ x4 ^ x2;
    end
    return {me[0] ^ mb[1] ^ md[2] ^ m9[3],
            m9[0] ^ me[1] ^ mb[2] ^ md[3],
            md[0] ^ m9[1] ^ me[2] ^ mb[3],
            mb[0] ^ md[1] ^ m9[2] ^ me[3]};
  endfunction

  function automatic logic [127:0] inv_mix_columns(input logic [127:0] x);
    return {inv_mix_col(x[127:96]), inv_mix_col(x[95:64]),
            inv_mix_col(x[63:32]),  inv_mix_col(x[31:0])};
  endfunction

  assign w_accept   = bus.load && ((r_state == S_IDLE) || (r_state == S_DONE));
  assign w_prev_idx = (r_rc == 4'd0) ? 4'd0 : r_rc - 4'd1;
  assign w_rk_prev  = r_rk[w_prev_idx];

  // Next round key: SubWord(RotWord(w3)) comes back from the shared S-box.
  assign w_temp    = bus.subword_out ^ {rcon(r_rc), 24'h000000};
  assign w_k0      = w_rk_prev[127:96] ^ w_temp;
  assign w_k1      = w_rk_prev[95:64]  ^ w_k0;
  assign w_k2      = w_rk_prev[63:32]  ^ w_k1;
  assign w_k3      = w_rk_prev[31:0]   ^ w_k2;
  assign w_rk_next = {w_k0, w_k1, w_k2, w_k3};

  assign bus.subword_in = (r_state == S_KEXP) ? {w_rk_prev[23:0], w_rk_prev[31:24]} : 32'h0;
  assign bus.invsub_in  = ((r_state == S_ROUND) || (r_state == S_FINAL)) ?
                          inv_shift_rows(r_blk) : 128'h0;
  assign bus.plaintext  = r_pt;
  assign bus.done       = r_done;
  assign bus.busy       = r_busy;

`ifdef AES_INV_KEY_CACHE_EN
  logic [127:0] r_key_cache;
  logic         r_key_valid;

  assign w_hit = r_key_valid && (bus.key == r_key_cache);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_key_valid <= 1'b0;
      r_key_cache <= '0;
    end else if (w_accept && !w_hit) begin
      r_key_valid <= 1'b0;
    end else if ((r_state == S_KEXP) && (r_rc == 4'(NR))) begin
      r_key_valid <= 1'b1;
      r_key_cache <= r_rk[0];
    end
  end
`else
  assign w_hit = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE, S_DONE: if (bus.load) w_next = w_hit ? S_INIT : S_KEXP;
      S_KEXP:         if (r_rc == 4'(NR)) w_next = S_INIT;
      S_INIT:         w_next = S_ROUND;
      S_ROUND:        if (r_rc == 4'd1) w_next = S_FINAL;
      S_FINAL:        w_next = S_DONE;
      default:        w_next = S_IDLE;
    endcase
  end

  // Round-key buffer contents are meaningless after reset, so it has none.
  always_ff @(posedge clk) begin
    if (w_accept)                 r_rk[0]    <= bus.key;
    else if (r_state == S_KEXP)   r_rk[r_rc] <= w_rk_next;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rc   <= 4'd0;
      r_blk  <= '0;
      r_pt   <= '0;
      r_done <= 1'b0;
      r_busy <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (bus.load) begin
            r_blk  <= bus.ciphertext;
            r_rc   <= 4'd1;
            r_done <= 1'b0;
            r_busy <= 1'b1;
          end
        end
        S_KEXP: begin
          if (r_rc != 4'(NR)) r_rc <= r_rc + 4'd1;
        end
        S_INIT: begin
          r_blk <= r_blk ^ r_rk[NR];
          r_rc  <= 4'(NR - 1);
        end
        S_ROUND: begin
          r_blk <= inv_mix_columns(bus.invsub_out ^ r_rk[r_rc]);
          r_rc  <= r_rc - 4'd1;
        end
        S_FINAL: begin
          r_pt   <= bus.invsub_out ^ r_rk[0];
          r_done <= 1'b1;
          r_busy <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_aes_inv_cipher.sv
`default_nettype none
// ============================================================================
// Module  : tb_aes_inv_cipher
// Brief   : Self-checking bench: FIPS-197 vectors plus random blocks against a
//           byte-level AES decryption and cycle-timing model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_aes_inv_cipher;

  localparam logic [127:0] KB  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] CB  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] PB  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] RKB = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] KC  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] CC  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] PC  = 128'h00112233445566778899aabbccddeeff;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  int   checks = 0;
  int   errors = 0;

  aes_inv_cipher_if u_if ();

  aes_inv_cipher #(.NR(10)) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (u_if)
  );

  always #5 clk = ~clk;

  // ---------------- GF(2^8) and S-box arithmetic ----------------
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    logic [7:0] bb;
    p = 8'h00; aa = a; bb = b;
    for (int i = 0; i < 8; i++) begin
      if (bb[0]) p = p ^ aa;
      aa = aa[7] ? ({aa[6:0], 1'b0} ^ 8'h1b) : {aa[6:0], 1'b0};
      bb = {1'b0, bb[7:1]};
    end
    return p;
  endfunction

  function automatic logic [7:0] ginv(input logic [7:0] a);
    logic [7:0] r;
    logic [7:0] p;
    int e;
    r = 8'h01; p = a; e = 254;
    while (e != 0) begin
      if (e % 2 == 1) r = gmul(r, p);
      p = gmul(p, p);
      e = e / 2;
    end
    return r;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] x, input int n);
    logic [15:0] d;
    d = {x, x} << n;
    return d[15:8];
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] b;
    b = ginv(x);
    return b ^ rotl(b, 1) ^ rotl(b, 2) ^ rotl(b, 3) ^ rotl(b, 4) ^ 8'h63;
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] y);
    return ginv(rotl(y, 1) ^ rotl(y, 3) ^ rotl(y, 6) ^ 8'h05);
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  function automatic logic [127:0] inv_sub_state(input logic [127:0] s);
    logic [127:0] o;
    for (int i = 0; i < 16; i++) o[127-8*i -: 8] = inv_sbox(s[127-8*i -: 8]);
    return o;
  endfunction

  // External S-box units
  assign u_if.subword_out = sub_word(u_if.subword_in);
  assign u_if.invsub_out  = inv_sub_state(u_if.invsub_in);

  // ---------------- Reference AES-128 decryption ----------------
  function automatic logic [127:0] expand_rk(input logic [127:0] k, input int rnd);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t  = sub_word({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    return {w[4*rnd], w[4*rnd+1], w[4*rnd+2], w[4*rnd+3]};
  endfunction

  function automatic logic [127:0] aes_dec(input logic [127:0] k, input logic [127:0] c);
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [127:0] rk;
    logic [127:0] o;
    rk = expand_rk(k, 10);
    for (int i = 0; i < 16; i++) s[i] = c[127-8*i -: 8] ^ rk[127-8*i -: 8];
    for (int r = 9; r >= 0; r--) begin
      for (int col = 0; col < 4; col++)
        for (int row = 0; row < 4; row++)
          t[row+4*col] = s[row+4*((col-row+4)%4)];
      rk = expand_rk(k, r);
      for (int i = 0; i < 16; i++) t[i] = inv_sbox(t[i]) ^ rk[127-8*i -: 8];
      if (r > 0) begin
        for (int col = 0; col < 4; col++) begin
          s[4*col+0] = gmul(t[4*col],8'h0e)^gmul(t[4*col+1],8'h0b)^gmul(t[4*col+2],8'h0d)^gmul(t[4*col+3],8'h09);
          s[4*col+1] = gmul(t[4*col],8'h09)^gmul(t[4*col+1],8'h0e)^gmul(t[4*col+2],8'h0b)^gmul(t[4*col+3],8'h0d);
          s[4*col+2] = gmul(t[4*col],8'h0d)^gmul(t[4*col+1],8'h09)^gmul(t[4*col+2],8'h0e)^gmul(t[4*col+3],8'h0b);
          s[4*col+3] = gmul(t[4*col],8'h0b)^gmul(t[4*col+1],8'h0d)^gmul(t[4*col+2],8'h09)^gmul(t[4*col+3],8'h0e);
        end
      end else begin
        for (int i = 0; i < 16; i++) s[i] = t[i];
      end
    end
    for (int i = 0; i < 16; i++) o[127-8*i -: 8] = s[i];
    return o;
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- Cycle-level timing model ----------------
  logic         m_busy = 1'b0;
  logic         m_done = 1'b0;
  logic [127:0] m_pt   = '0;
  logic [127:0] m_pend = '0;
  int           m_cnt  = 0;
  int           m_lat  = 0;
  logic         m_cv   = 1'b0;
  logic [127:0] m_ck   = '0;
  logic [127:0] m_pk   = '0;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_busy = 1'b0; m_done = 1'b0; m_pt = '0; m_cnt = 0; m_cv = 1'b0;
    end else if (!m_busy) begin
      if (u_if.load) begin
        m_pend = aes_dec(u_if.key, u_if.ciphertext);
        m_pk   = u_if.key;
`ifdef AES_INV_KEY_CACHE_EN
        m_cnt  = (m_cv && (m_ck == u_if.key)) ? 11 : 21;
        if (m_cnt == 21) m_cv = 1'b0;
`else
        m_cnt  = 21;
`endif
        m_lat  = m_cnt;
        m_busy = 1'b1;
        m_done = 1'b0;
      end
    end else begin
      m_cnt--;
      if (m_cnt == 0) begin
        m_busy = 1'b0;
        m_done = 1'b1;
        m_pt   = m_pend;
        m_cv   = 1'b1;
        m_ck   = m_pk;
      end
    end
  end

  always @(negedge clk) begin
    chk("done", 128'(u_if.done), 128'(m_done));
    chk("busy", 128'(u_if.busy), 128'(m_busy));
    chk("plaintext", u_if.plaintext, m_pt);
    if (!m_busy) begin
      chk("subword_in_idle", 128'(u_if.subword_in), 128'h0);
      chk("invsub_in_idle", u_if.invsub_in, 128'h0);
    end
  end

  // ---------------- Stimulus ----------------
  task automatic run_block(input logic [127:0] k, input logic [127:0] c,
                           input int junk_at, output int lat);
    int n;
    bit got;
    @(negedge clk);
    u_if.load = 1'b1; u_if.key = k; u_if.ciphertext = c;
    @(posedge clk);
    @(negedge clk);
    u_if.key = rnd128(); u_if.ciphertext = rnd128();
    n = 0; got = 1'b0;
    while (!got && n < 40) begin
      u_if.load = (n == junk_at);
      @(posedge clk); n++;
      @(negedge clk);
      got = u_if.done;
    end
    u_if.load = 1'b0;
    chk("done_seen", 128'(got), 128'd1);
    lat = n;
  endtask

  task automatic wait_done(output bit got);
    int n;
    n = 0;
    do begin
      @(posedge clk); n++;
      @(negedge clk);
    end while (!u_if.done && n < 50);
    got = u_if.done;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    int lat;
    bit got;
    logic [127:0] k, c, pk;
    u_if.load = 1'b0; u_if.key = '0; u_if.ciphertext = '0;
    #1 reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;

    chk("model_rk10_B", expand_rk(KB, 10), RKB);
    chk("model_pt_B", aes_dec(KB, CB), PB);
    chk("model_pt_C", aes_dec(KC, CC), PC);
    chk("reset_pt", u_if.plaintext, 128'h0);
    chk("reset_done", 128'(u_if.done), 128'h0);

    run_block(KB, CB, -1, lat);
    chk("lat_B", 128'(lat), 128'd21);
    chk("pt_B", u_if.plaintext, PB);

    run_block(KC, CC, -1, lat);
    chk("lat_C", 128'(lat), 128'd21);
    chk("pt_C", u_if.plaintext, PC);

    // Second load at edge 5 must be ignored
    run_block(KB, CB, 4, lat);
    chk("lat_ignore", 128'(lat), 128'd21);
    chk("pt_ignore", u_if.plaintext, PB);

    // Asynchronous reset in the middle of a block
    @(negedge clk);
    u_if.load = 1'b1; u_if.key = KC; u_if.ciphertext = CC;
    @(posedge clk);
    @(negedge clk);
    u_if.load = 1'b0;
    repeat (15) @(posedge clk);
    #2 reset = 1'b1;
    #1;
    chk("async_rst_pt", u_if.plaintext, 128'h0);
    chk("async_rst_done", 128'(u_if.done), 128'h0);
    chk("async_rst_busy", 128'(u_if.busy), 128'h0);
    @(negedge clk);
    reset = 1'b0;
    run_block(KB, CB, -1, lat);
    chk("lat_after_rst", 128'(lat), 128'd21);
    chk("pt_after_rst", u_if.plaintext, PB);

    // Back-to-back with load held high
    @(negedge clk);
    u_if.load = 1'b1; u_if.key = KB; u_if.ciphertext = CB;
    wait_done(got);
    chk("b2b_first_done", 128'(got), 128'd1);
    chk("b2b_pt_B", u_if.plaintext, PB);
    u_if.key = KC; u_if.ciphertext = CC;
    wait_done(got);
    u_if.load = 1'b0;
    chk("b2b_second_done", 128'(got), 128'd1);
    chk("b2b_pt_C", u_if.plaintext, PC);

    // Random blocks, with key reuse, gaps and ignored mid-run loads
    pk = rnd128();
    for (int i = 0; i < 12; i++) begin
      k = ($urandom_range(0, 1) == 1) ? pk : rnd128();
      c = rnd128();
      repeat ($urandom_range(0, 3)) @(negedge clk);
      run_block(k, c, ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 8)) : -1, lat);
      chk("rand_lat", 128'(lat), 128'(m_lat));
      chk("rand_pt", u_if.plaintext, aes_dec(k, c));
      pk = k;
    end

`ifdef AES_INV_KEY_CACHE_EN
    run_block(KC, CC, -1, lat);
    run_block(KB, CB, -1, lat);
    chk("cache_miss_lat", 128'(lat), 128'd21);
    run_block(KB, CB, -1, lat);
    chk("cache_hit_lat", 128'(lat), 128'd11);
    chk("cache_hit_pt", u_if.plaintext, PB);
    run_block(KC, CC, -1, lat);
    chk("cache_change_lat", 128'(lat), 128'd21);
    chk("cache_change_pt", u_if.plaintext, PC);
`endif

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/aes_inv_cipher.md
Name: aes_inv_cipher

Overview:
AES-128 inverse cipher (decryption) engine: the receive-side counterpart of the forward CIPHER FSM.
- Accepts a 128-bit key and a ciphertext block.
- Expands the key schedule forward into an internal 11-entry round-key buffer.
- Replays the round keys in reverse order (10 down to 0) through iterative inverse rounds, one round per clock.
- S-box lookups go to external combinational units (forward S-box for SubWord, inverse S-box for InvSubBytes), so the existing sbox modules are shared.

Parameters:
- NR, 10, number of AES rounds; fixed for AES-128, not intended to be overridden.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- reset  input  1  asynchronous, active-high reset.
- load  input  1  start pulse; sampled on a rising edge while idle or done.
- key  input  128  cipher key; byte 0 = key[127:120].
- ciphertext  input  128  input block; FIPS-197 column-major byte order, byte 0 = [127:120].
- plaintext  output  128  decrypted block; valid while done=1.
- done  output  1  high from completion until the next accepted load or reset.
- busy  output  1  high while key expansion or rounds are in progress.
- subword_in  output  32  word sent to external forward S-box (RotWord already applied).
- subword_out  input  32  S-box result, combinational from subword_in.
- invsub_in  output  128  state sent to external inverse S-box (after InvShiftRows).
- invsub_out  input  128  inverse S-box result, combinational from invsub_in.

Behaviour:
- Reset (asynchronous, active-high): state IDLE; plaintext=0, done=0, busy=0; round counter=0; state register=0; key buffer contents don't-care (valid flag cleared).
- FSM states: IDLE, KEXP, INIT, ROUND, FINAL, DONE.
- IDLE/DONE, load=1 at a rising edge:
  - rk[0]<=key, state<=ciphertext, rc<=1, done<=0, busy<=1; go to KEXP.
- KEXP: each edge writes rk[rc] from rk[rc-1] using SubWord(RotWord(w3)) ^ Rcon[rc].
  - Rcon = 01,02,04,08,10,20,40,80,1b,36.
  - After rc=10, go to INIT.
- INIT: state<=state ^ rk[10]; rc<=9; go to ROUND.
- ROUND (rc=9..1), one edge per round:
  - state <= InvMixColumns(invsub_out ^ rk[rc]), where invsub_in = InvShiftRows(state).
  - rc decrements; after rc=1, go to FINAL.
- FINAL: plaintext<=invsub_out ^ rk[0]; done<=1, busy<=0; go to DONE.
- Latency: done rises on the 21st rising edge after the edge that sampled load (10 KEXP + 1 INIT + 9 ROUND + 1 FINAL).
- DONE: plaintext and done held stable until a new load is accepted. The accepting edge clears done and leaves plaintext unchanged until the next FINAL.
- load while busy=1: ignored, no restart; key/ciphertext changes mid-operation have no effect (values were captured at load).
- load held high continuously: restarts on the first edge in DONE; done is therefore high for exactly one cycle per block.
- Reset mid-operation: immediate return to IDLE with reset values; no partial plaintext is exposed.
- Outputs when not in use:
  - subword_in = RotWord(rk[rc-1][31:0]) in KEXP, else 0.
  - invsub_in = InvShiftRows(state) in ROUND/FINAL, else 0.
- InvMixColumns uses GF(2^8) xtime with polynomial 0x11b; multipliers 0e, 0b, 0d, 09.

Optional Feature:
- Macro: AES_INV_KEY_CACHE_EN.
- Defined:
  - A 128-bit cached-key register and a key_valid flag are kept.
  - On load with key_valid=1 and key equal to the cached key, KEXP is skipped: state goes directly to INIT and done rises on the 11th edge after load.
  - A completed KEXP sets key_valid and stores the key.
  - Reset clears key_valid.
- Not defined: every load runs KEXP; latency is always 21 cycles; no extra registers.

Test Plan:
- FIPS-197 App. B: key 2b7e151628aed2a6abf7158809cf4f3c, ciphertext 3925841d02dc09fbdc118597196a0b32, pulse load -> done on edge 21, plaintext=3243f6a8885a308d313198a2e0370734, busy high edges 1-20; rk[10] probe = d014f9a8c9ee2589e13f0cc8b6630ca6.
- FIPS-197 App. C.1: key 000102030405060708090a0b0c0d0e0f, ciphertext 69c4e0d86a7b0430d8cdb78070b4c55a -> plaintext 00112233445566778899aabbccddeeff.
- Load ignored when busy: second load with different ciphertext at edge 5 -> result still matches the first block, done on edge 21 only.
- Reset mid-operation: assert reset at edge 15 -> plaintext=0, done=0, busy=0 asynchronously. Reload App. B vectors -> correct result 21 edges later.
- Back-to-back blocks: App. B then App. C.1, load on the cycle done is high -> done pulses once per block, both plaintexts correct.
- AES_INV_KEY_CACHE_EN defined: two App. B loads with the same key -> first completes in 21 edges, second in 11, same plaintext. Changing the key -> 21 edges again.
